// File: rtl/riscv_intc_pkg.sv
// Shared interrupt-controller types: channel trigger modes and the
// external-interrupt register offsets.
package riscv_intc_pkg;

  localparam int NUMINT = 4;

  typedef enum logic [1:0] {
    EXT_RISE  = 2'b00,
    EXT_FALL  = 2'b01,
    EXT_BOTH  = 2'b10,
    EXT_LEVEL = 2'b11
  } extint_mode_t;

  localparam logic [3:0] EXTINT_STAT = 4'h0;
  localparam logic [3:0] EXTINT_IE   = 4'h4;
  localparam logic [3:0] EXTINT_MODE = 4'h8;
  localparam logic [3:0] EXTINT_PEND = 4'hC;

endpackage

// File: rtl/riscv_extint_ctrl_if.sv
// Data-bus slave port of the external-interrupt controller.
interface riscv_extint_ctrl_if #(
  parameter int XLEN = 32
);
  logic            sel;
  logic            enable;
  logic            write;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata;

  modport master (output sel, enable, write, addr, wdata, input rdata);
  modport slave  (input sel, enable, write, addr, wdata, output rdata);
endinterface

// File: rtl/riscv_extint_chan.sv
// One interrupt channel: synchronizer, optional debouncer, edge/level detector.
// Debouncer present only when RISCV_EXTINT_DBNC_EN is defined.
module riscv_extint_chan
  import riscv_intc_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int DBNC_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_raw,
  input  extint_mode_t i_mode,
  output logic         o_lvl,
  output logic         o_evt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_dprev;

  always_ff @(posedge clk) begin
    if (!rstn) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef RISCV_EXTINT_DBNC_EN
  localparam int CW = $clog2(DBNC_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_d;

  // d takes s on the DBNC_CYCLES-th consecutive cycle that they differ
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_d   <= 1'b0;
    end else if (w_s == r_d) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DBNC_CYCLES - 1)) begin
      r_d   <= w_s;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_lvl = r_d;
`else
  logic w_unused_dbnc;
  assign w_unused_dbnc = (DBNC_CYCLES != 0);
  assign o_lvl         = w_s;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) r_dprev <= 1'b0;
    else       r_dprev <= o_lvl;
  end

  always_comb begin
    o_evt = 1'b0;
    case (i_mode)
      EXT_RISE:  o_evt = o_lvl & ~r_dprev;
      EXT_FALL:  o_evt = ~o_lvl & r_dprev;
      EXT_BOTH:  o_evt = o_lvl ^ r_dprev;
      EXT_LEVEL: o_evt = o_lvl;
      default:   o_evt = 1'b0;
    endcase
  end

endmodule

// File: rtl/riscv_extint_ctrl.sv
// External-interrupt controller: NCH conditioned channels, IE/MODE/PEND bus slave.
// RISCV_EXTINT_DBNC_EN enables the per-channel debouncer.
module riscv_extint_ctrl
  import riscv_intc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 3,
  parameter int DBNC_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rstn,
  riscv_extint_ctrl_if.slave  bus,
  input  logic [NCH-1:0]      irq_i,
  output logic [NCH-1:0]      irq_o
);

  logic [NCH-1:0]   w_lvl;
  logic [NCH-1:0]   w_evt;
  logic [NCH-1:0]   r_ie;
  logic [NCH-1:0]   r_pend;
  logic [2*NCH-1:0] r_mode;
  logic [XLEN-1:0]  r_rdata;
  logic [XLEN-1:0]  w_rval;
  logic [NCH-1:0]   w_clr;
  logic [3:0]       w_off;
  logic             w_wr;
  logic             w_rd;
  logic             w_unused;

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    riscv_extint_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DBNC_CYCLES (DBNC_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .i_raw  (irq_i[n]),
      .i_mode (extint_mode_t'(r_mode[2*n +: 2])),
      .o_lvl  (w_lvl[n]),
      .o_evt  (w_evt[n])
    );
  end

  assign w_off    = {bus.addr[3:2], 2'b00};
  assign w_wr     = bus.sel & bus.enable & bus.write;
  assign w_rd     = bus.sel & bus.enable & ~bus.write;
  assign w_clr    = (w_wr && w_off == EXTINT_PEND) ? bus.wdata[NCH-1:0] : '0;
  assign w_unused = ^{bus.addr[XLEN-1:4], bus.addr[1:0], bus.wdata};

  always_comb begin
    w_rval = '0;
    case (w_off)
      EXTINT_STAT: w_rval[NCH-1:0]   = w_lvl;
      EXTINT_IE:   w_rval[NCH-1:0]   = r_ie;
      EXTINT_MODE: w_rval[2*NCH-1:0] = r_mode;
      EXTINT_PEND: w_rval[NCH-1:0]   = r_pend;
      default:     w_rval            = '0;
    endcase
  end

  // Event set wins over W1C, so level mode cannot clear while d is high
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ie    <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_rdata <= '0;
    end else begin
      r_pend <= w_evt | (r_pend & ~w_clr);
      if (w_wr && w_off == EXTINT_IE)   r_ie   <= bus.wdata[NCH-1:0];
      if (w_wr && w_off == EXTINT_MODE) r_mode <= bus.wdata[2*NCH-1:0];
      if (w_rd)                         r_rdata <= w_rval;
    end
  end

  assign bus.rdata = r_rdata;
  assign irq_o     = r_pend & r_ie;

endmodule

// File: tb/tb_riscv_extint_ctrl.sv
// Scoreboard bench for riscv_extint_ctrl: directed scenarios then random traffic,
// checked against a delay-line / run-length reference model.
`timescale 1ns/1ps
module tb_riscv_extint_ctrl;
  import riscv_intc_pkg::*;

  localparam int XLEN = 32;
  localparam int NCH  = 4;
  localparam int SYNC = 3;
  localparam int DBNC = 8;
`ifdef RISCV_EXTINT_DBNC_EN
  localparam int DB = DBNC;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = SYNC + DB + 1;

  logic           clk  = 1'b0;
  logic           rstn = 1'b0;
  logic [NCH-1:0] irq_i = '0;
  logic [NCH-1:0] irq_o;

  riscv_extint_ctrl_if #(.XLEN(XLEN)) bus ();

  riscv_extint_ctrl #(
    .XLEN(XLEN), .NCH(NCH), .SYNC_STAGES(SYNC), .DBNC_CYCLES(DBNC)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .irq_i(irq_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit             m_in [NCH][$];   // irq_i history, index 0 = most recent edge
  logic [NCH-1:0] m_d, m_dp, m_ie, m_pend;
  int             m_run  [NCH];
  int             m_mode [NCH];
  bit             m_rdv;
  logic [31:0]    exp_q [$];

  function automatic bit ev_of(input int md, input bit d, input bit dp);
    case (md)
      0:       return d && !dp;
      1:       return !d && dp;
      2:       return d != dp;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    bit             wr, s;
    int             off;
    logic [31:0]    mv;
    logic [NCH-1:0] ev, clr;
    if (!rstn) begin
      m_d = '0; m_dp = '0; m_ie = '0; m_pend = '0; m_rdv = 0;
      for (int n = 0; n < NCH; n++) begin
        m_run[n] = 0; m_mode[n] = 0; m_in[n] = {};
        repeat (SYNC) m_in[n].push_back(1'b0);
      end
    end else begin
      wr    = bus.sel && bus.enable && bus.write;
      m_rdv = bus.sel && bus.enable && !bus.write;
      off   = int'(bus.addr[3:2]);
      mv    = '0;
      for (int n = 0; n < NCH; n++) mv = mv | (32'(m_mode[n]) << (2*n));
      if (m_rdv)
        case (off)
          0: exp_q.push_back(32'(m_d));
          1: exp_q.push_back(32'(m_ie));
          2: exp_q.push_back(mv);
          default: exp_q.push_back(32'(m_pend));
        endcase
      for (int n = 0; n < NCH; n++) ev[n] = ev_of(m_mode[n], m_d[n], m_dp[n]);
      clr    = (wr && off == 3) ? bus.wdata[NCH-1:0] : '0;
      m_pend = ev | (m_pend & ~clr);
      if (wr && off == 1) m_ie = bus.wdata[NCH-1:0];
      if (wr && off == 2)
        for (int n = 0; n < NCH; n++) m_mode[n] = int'(bus.wdata[2*n +: 2]);
      m_dp = m_d;
      for (int n = 0; n < NCH; n++) begin
        s = m_in[n][SYNC-1];
`ifdef RISCV_EXTINT_DBNC_EN
        if (s == m_d[n]) m_run[n] = 0;
        else begin
          m_run[n]++;
          if (m_run[n] >= DB) begin m_d[n] = s; m_run[n] = 0; end
        end
`endif
        m_in[n].push_front(irq_i[n]);
        void'(m_in[n].pop_back());
`ifndef RISCV_EXTINT_DBNC_EN
        m_d[n] = m_in[n][SYNC-1];
`endif
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (m_rdv) begin
      if (exp_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
      else                   chk("rdata", bus.rdata, exp_q.pop_front());
    end
    chk("irq_o", 32'(irq_o), 32'(m_pend & m_ie));
  end

  // ---------------- stimulus ----------------
  task automatic acc(input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.enable = 1'b1; bus.write = w; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.enable = 1'b0; bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_all();
    acc(0, 32'(EXTINT_STAT), 0);
    acc(0, 32'(EXTINT_IE),   0);
    acc(0, 32'(EXTINT_MODE), 0);
    acc(0, 32'(EXTINT_PEND), 0);
  endtask

  initial begin
    int k;
    bus.sel = 0; bus.enable = 0; bus.write = 0; bus.addr = '0; bus.wdata = '0;
    idle(3);
    rstn = 1'b1;
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_irq", 32'(irq_o), 0);
    read_all();

    // ch0 rising, latency
    acc(1, 32'(EXTINT_IE), 32'h1);
    acc(1, 32'(EXTINT_MODE), 32'h0);
    irq_i[0] = 1'b1;
    k = 0;
    while (k < 40 && !irq_o[0]) begin @(negedge clk); k++; end
    chk("lat_ch0", k, LAT);
    acc(1, 32'(EXTINT_PEND), 32'h1);
    chk("w1c_irq0", 32'(irq_o[0]), 0);

    // ch1 falling, short glitch then long pulse
    acc(1, 32'(EXTINT_MODE), 32'h04);
    acc(1, 32'(EXTINT_IE), 32'h3);
    irq_i[1] = 1'b1; idle(5); irq_i[1] = 1'b0;
    idle(30);
    acc(0, 32'(EXTINT_STAT), 0);
    acc(0, 32'(EXTINT_PEND), 0);
    chk("glitch_irq1", 32'(irq_o[1]), (DB == 0) ? 32'd1 : 32'd0);
    acc(1, 32'(EXTINT_PEND), 32'h2);
    irq_i[1] = 1'b1; idle(20);
    acc(0, 32'(EXTINT_PEND), 0);
    chk("rise_in_fall", 32'(irq_o[1]), 0);
    irq_i[1] = 1'b0; idle(30);
    acc(0, 32'(EXTINT_PEND), 0);
    chk("fall_irq1", 32'(irq_o[1]), 1);

    // ch2 level
    acc(1, 32'(EXTINT_MODE), 32'h34);
    acc(1, 32'(EXTINT_IE), 32'h7);
    irq_i[2] = 1'b1; idle(20);
    acc(1, 32'(EXTINT_PEND), 32'h4);
    acc(0, 32'(EXTINT_PEND), 0);
    chk("lvl_hold", 32'(irq_o[2]), 1);
    irq_i[2] = 1'b0; idle(LAT);
    acc(1, 32'(EXTINT_PEND), 32'h4);
    chk("lvl_clr", 32'(irq_o[2]), 0);

    // ch3 both edges, masked then enabled
    acc(1, 32'(EXTINT_MODE), 32'hB4);
    irq_i[3] = 1'b1; idle(20);
    acc(0, 32'(EXTINT_PEND), 0);
    chk("both_masked", 32'(irq_o[3]), 0);
    acc(1, 32'(EXTINT_IE), 32'h8);
    chk("both_ie", 32'(irq_o[3]), 1);

    // event on ch0 in the same cycle as its W1C
    acc(1, 32'(EXTINT_IE), 32'h9);
    irq_i[0] = 1'b0; idle(20);
    acc(1, 32'(EXTINT_PEND), 32'hF);
    chk("pre_coll", 32'(irq_o[0]), 0);
    irq_i[0] = 1'b1;
    idle(LAT - 1);
    acc(1, 32'(EXTINT_PEND), 32'h1);
    chk("coll_irq0", 32'(irq_o[0]), 1);

    // reset mid-debounce on ch1
    irq_i[1] = 1'b1; idle(SYNC + 3);
    rstn = 1'b0; irq_i = '0; idle(2);
    rstn = 1'b1;
    chk("rst2_rdata", bus.rdata, 0);
    chk("rst2_irq", 32'(irq_o), 0);
    read_all();

    // random traffic
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0: begin irq_i[$urandom_range(0, NCH-1)] ^= 1'b1; idle($urandom_range(1, 14)); end
        1: acc(1, $urandom, $urandom);
        2: acc(0, $urandom, 0);
        default: idle($urandom_range(1, 4));
      endcase
    end
    idle(2);
    chk("q_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
